rp_sd_arbiter: RTL and testbench

- Parametrised N-drive arbiter between the RPxx drive array and the single SD controller; successor to the fixed 8-drive scan in the RP disk top level.
- Grants the SD port round-robin, latches the winning drive's operation and linear sector address, and runs a four-phase req/ack handshake with both sides.
- Adds a per-transaction watchdog with a sticky per-drive timeout flag; the fixed-scan design has neither fairness guarantees nor timeout.

---
 rtl/rp_sd_arbiter_if.sv | 34 +++
 rtl/rp_sd_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rp_sd_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rp_sd_arbiter_if.sv
// rp_sd_arbiter_if: drive-array and SD-controller signals of the arbiter.
// Modports: master = arbiter side, slave = drives/SD controller side.
interface rp_sd_arbiter_if #(
  parameter int NUM_DRV = 8,
  parameter int OP_W    = 3,
  parameter int LSA_W   = 21
);
  localparam int SW = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;

  logic [NUM_DRV-1:0]       drvREQ;
  logic [NUM_DRV*OP_W-1:0]  drvOP;
  logic [NUM_DRV*LSA_W-1:0] drvLSA;
  logic [NUM_DRV-1:0]       drvACK;
  logic [NUM_DRV-1:0]       drvTMO;
  logic                     sdREQ;
  logic [OP_W-1:0]          sdOP;
  logic [LSA_W-1:0]         sdLSA;
  logic                     sdDONE;
  logic [SW-1:0]            sdSCAN;
  logic                     busy;
  logic                     tmoPULSE;

  modport master (
    input  drvREQ, drvOP, drvLSA, sdDONE,
    output drvACK, drvTMO, sdREQ, sdOP, sdLSA,
    output sdSCAN, busy, tmoPULSE
  );

  modport slave (
    output drvREQ, drvOP, drvLSA, sdDONE,
    input  drvACK, drvTMO, sdREQ, sdOP, sdLSA,
    input  sdSCAN, busy, tmoPULSE
  );
endinterface

// File: rtl/rp_sd_arbiter.sv
// rp_sd_arbiter: round-robin grant of the SD controller to NUM_DRV drives,
// 4-phase req/ack on both sides, per-transfer watchdog with sticky flags.
// Ports: clk, rst (async, active-low), clr (sync INIT), bus (master).
module rp_sd_arbiter #(
  parameter int NUM_DRV = 8,
  parameter int OP_W    = 3,
  parameter int LSA_W   = 21,
  parameter int TO_W    = 20
) (
  input logic             clk,
  input logic             rst,
  input logic             clr,
  rp_sd_arbiter_if.master bus
);
  localparam int SW = (NUM_DRV > 1) ? $clog2(NUM_DRV) : 1;
  localparam logic [SW-1:0] LAST_RST = SW'(NUM_DRV - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      last_q, last_d;
  logic [SW-1:0]      scan_q, scan_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [LSA_W-1:0]   lsa_q, lsa_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               tpls_q, tpls_d;
  logic [NUM_DRV-1:0] ack_q, ack_d;
  logic [NUM_DRV-1:0] tmo_q, tmo_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;

  logic [SW-1:0]      win;
  logic               found;
  logic [OP_W-1:0]    op_win;
  logic [LSA_W-1:0]   lsa_win;
  logic [NUM_DRV-1:0] scan_oh;
  logic               scan_req;

  // Rotating priority: indices above last first, then wrap to 0..last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (!found && bus.drvREQ[i] && i > int'(last_q)) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
    for (int i = 0; i < NUM_DRV; i++) begin
      if (!found && bus.drvREQ[i] && i <= int'(last_q)) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
  end

  always_comb begin
    op_win  = '0;
    lsa_win = '0;
    scan_oh = '0;
    for (int i = 0; i < NUM_DRV; i++) begin
      if (win == SW'(i)) begin
        op_win  = bus.drvOP[i*OP_W +: OP_W];
        lsa_win = bus.drvLSA[i*LSA_W +: LSA_W];
      end
      scan_oh[i] = (scan_q == SW'(i));
    end
  end

  assign scan_req = |(bus.drvREQ & scan_oh);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    scan_d  = scan_q;
    op_d    = op_q;
    lsa_d   = lsa_q;
    req_d   = req_q;
    busy_d  = busy_q;
    tpls_d  = 1'b0;
    ack_d   = '0;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          scan_d  = win;
          op_d    = op_win;
          lsa_d   = lsa_win;
          req_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // sdDONE beats a coincident terminal count.
        if (bus.sdDONE || cnt_q == '1) begin
          req_d   = 1'b0;
          ack_d   = scan_oh;
          last_d  = scan_q;
          state_d = HOLD;
          if (!bus.sdDONE) begin
            tmo_d  = tmo_q | scan_oh;
            tpls_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!scan_req) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d = IDLE;
      last_d  = LAST_RST;
      scan_d  = '0;
      op_d    = '0;
      lsa_d   = '0;
      req_d   = 1'b0;
      busy_d  = 1'b0;
      tpls_d  = 1'b0;
      ack_d   = '0;
      tmo_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      scan_q  <= '0;
      op_q    <= '0;
      lsa_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      tpls_q  <= 1'b0;
      ack_q   <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      scan_q  <= scan_d;
      op_q    <= op_d;
      lsa_q   <= lsa_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      tpls_q  <= tpls_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.drvACK   = ack_q;
  assign bus.drvTMO   = tmo_q;
  assign bus.sdREQ    = req_q;
  assign bus.sdOP     = op_q;
  assign bus.sdLSA    = lsa_q;
  assign bus.sdSCAN   = scan_q;
  assign bus.busy     = busy_q;
  assign bus.tmoPULSE = tpls_q;
endmodule

// File: tb/tb_rp_sd_arbiter.sv
// tb_rp_sd_arbiter: directed bench for rp_sd_arbiter (8 drives, TO_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rp_sd_arbiter;
  localparam int N   = 8;
  localparam int OPW = 3;
  localparam int LW  = 21;
  localparam int TW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rp_sd_arbiter_if #(.NUM_DRV(N), .OP_W(OPW), .LSA_W(LW)) bus ();

  rp_sd_arbiter #(
    .NUM_DRV(N), .OP_W(OPW), .LSA_W(LW), .TO_W(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_table();
    for (int i = 0; i < N; i++) begin
      bus.drvOP[i*OPW +: OPW] = OPW'(i);
      bus.drvLSA[i*LW +: LW]  = LW'(32'h100 + i);
    end
  endtask

  // Wait for a grant, check it, complete after dly cycles, release.
  task automatic serve(input int idx, input int dly, input bit again);
    int n;
    logic [2:0] b;
    b = idx[2:0];
    n = 0;
    while (!bus.sdREQ && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("grant_sdREQ", 32'(bus.sdREQ), 32'd1);
    chk("grant_sdSCAN", 32'(bus.sdSCAN), 32'(idx));
    chk("grant_sdOP", 32'(bus.sdOP), 32'(idx));
    chk("grant_sdLSA", 32'(bus.sdLSA), 32'h100 + 32'(idx));
    repeat (dly) @(negedge clk);
    bus.sdDONE = 1'b1;
    @(negedge clk);
    bus.sdDONE = 1'b0;
    chk("serve_ack", 32'(bus.drvACK), 32'd1 << idx);
    chk("serve_sdREQ_low", 32'(bus.sdREQ), 32'd0);
    bus.drvREQ[b] = 1'b0;
    @(negedge clk);
    chk("serve_ack_end", 32'(bus.drvACK), 32'd0);
    if (again) bus.drvREQ[b] = 1'b1;
  endtask

  initial begin
    bus.drvREQ = '0;
    bus.drvOP  = '0;
    bus.drvLSA = '0;
    bus.sdDONE = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdREQ", 32'(bus.sdREQ), 32'd0);
    chk("rst_ack", 32'(bus.drvACK), 32'd0);
    chk("rst_tmo", 32'(bus.drvTMO), 32'd0);
    chk("rst_scan", 32'(bus.sdSCAN), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_tpls", 32'(bus.tmoPULSE), 32'd0);
    chk("rst_op", 32'(bus.sdOP), 32'd0);
    chk("rst_lsa", 32'(bus.sdLSA), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic transfer on drive 0
    bus.drvOP[2:0]  = 3'd3;
    bus.drvLSA[20:0] = 21'h012345;
    bus.drvREQ = 8'h01;
    @(negedge clk);
    chk("t1_sdREQ", 32'(bus.sdREQ), 32'd1);
    chk("t1_sdOP", 32'(bus.sdOP), 32'd3);
    chk("t1_sdLSA", 32'(bus.sdLSA), 32'h12345);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_scan", 32'(bus.sdSCAN), 32'd0);
    bus.drvOP[2:0]   = 3'd5;
    bus.drvLSA[20:0] = 21'h0;
    @(negedge clk);
    chk("t1_op_held", 32'(bus.sdOP), 32'd3);
    chk("t1_lsa_held", 32'(bus.sdLSA), 32'h12345);
    bus.sdDONE = 1'b1;
    @(negedge clk);
    bus.sdDONE = 1'b0;
    chk("t1_ack", 32'(bus.drvACK), 32'h01);
    chk("t1_sdREQ_low", 32'(bus.sdREQ), 32'd0);
    @(negedge clk);
    chk("t1_ack_one", 32'(bus.drvACK), 32'd0);
    chk("t1_hold_busy", 32'(bus.busy), 32'd1);
    bus.drvREQ = 8'h00;
    @(negedge clk);
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    chk("t1_scan_kept", 32'(bus.sdSCAN), 32'd0);

    // Fairness between drives 0 and 7
    set_table();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.drvREQ = 8'h81;
    serve(0, 4, 1'b1);
    serve(7, 4, 1'b1);
    serve(0, 4, 1'b1);
    serve(7, 4, 1'b0);
    bus.drvREQ = 8'h00;
    @(negedge clk);

    // Make last=3, then all eight request
    bus.drvREQ = 8'h08;
    serve(3, 2, 1'b0);
    bus.drvREQ = 8'hFF;
    serve(4, 1, 1'b1);
    serve(5, 1, 1'b1);
    serve(6, 1, 1'b1);
    serve(7, 1, 1'b1);
    serve(0, 1, 1'b1);
    serve(1, 1, 1'b1);
    serve(2, 1, 1'b1);
    serve(3, 1, 1'b1);
    bus.drvREQ = 8'h00;
    @(negedge clk);

    // Watchdog on drive 2
    bus.drvREQ = 8'h04;
    @(negedge clk);
    chk("to_scan", 32'(bus.sdSCAN), 32'd2);
    repeat (15) @(negedge clk);
    chk("to_cnt15_req", 32'(bus.sdREQ), 32'd1);
    chk("to_cnt15_tpls", 32'(bus.tmoPULSE), 32'd0);
    @(negedge clk);
    chk("to_tpls", 32'(bus.tmoPULSE), 32'd1);
    chk("to_ack", 32'(bus.drvACK), 32'h04);
    chk("to_tmo", 32'(bus.drvTMO), 32'h04);
    chk("to_sdREQ", 32'(bus.sdREQ), 32'd0);
    @(negedge clk);
    chk("to_tpls_end", 32'(bus.tmoPULSE), 32'd0);
    chk("to_ack_end", 32'(bus.drvACK), 32'd0);
    chk("to_tmo_sticky", 32'(bus.drvTMO), 32'h04);
    bus.drvREQ = 8'h00;
    @(negedge clk);
    bus.drvREQ = 8'h20;
    serve(5, 2, 1'b0);
    chk("to_tmo_persist", 32'(bus.drvTMO), 32'h04);

    // sdDONE coincides with terminal count on drive 1
    bus.drvREQ = 8'h02;
    @(negedge clk);
    chk("tie_scan", 32'(bus.sdSCAN), 32'd1);
    repeat (15) @(negedge clk);
    bus.sdDONE = 1'b1;
    @(negedge clk);
    bus.sdDONE = 1'b0;
    chk("tie_ack", 32'(bus.drvACK), 32'h02);
    chk("tie_tpls", 32'(bus.tmoPULSE), 32'd0);
    chk("tie_tmo", 32'(bus.drvTMO), 32'h04);
    bus.drvREQ = 8'h00;
    @(negedge clk);

    // clr mid-BUSY (last=1 beforehand)
    bus.drvREQ = 8'h02;
    @(negedge clk);
    chk("clr_pre_scan", 32'(bus.sdSCAN), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_sdREQ", 32'(bus.sdREQ), 32'd0);
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_tmo", 32'(bus.drvTMO), 32'd0);
    chk("clr_scan", 32'(bus.sdSCAN), 32'd0);
    clr = 1'b0;
    bus.drvREQ = 8'h81;
    @(negedge clk);
    chk("clr_next_req", 32'(bus.sdREQ), 32'd1);
    chk("clr_next_scan", 32'(bus.sdSCAN), 32'd0);
    bus.sdDONE = 1'b1;
    @(negedge clk);
    bus.sdDONE = 1'b0;
    chk("clr_next_ack", 32'(bus.drvACK), 32'h01);
    bus.drvREQ = 8'h00;
    @(negedge clk);

    // Timeout on drive 4, then async reset mid-BUSY on drive 5
    bus.drvREQ = 8'h10;
    @(negedge clk);
    chk("rst_pre_scan4", 32'(bus.sdSCAN), 32'd4);
    repeat (16) @(negedge clk);
    chk("rst_pre_tmo", 32'(bus.drvTMO), 32'h10);
    bus.drvREQ = 8'h00;
    @(negedge clk);
    bus.drvREQ = 8'h20;
    @(negedge clk);
    chk("rst_pre_scan5", 32'(bus.sdSCAN), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_sdREQ", 32'(bus.sdREQ), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_tmo", 32'(bus.drvTMO), 32'd0);
    chk("arst_scan", 32'(bus.sdSCAN), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.drvREQ = 8'h81;
    @(negedge clk);
    chk("arst_next_req", 32'(bus.sdREQ), 32'd1);
    chk("arst_next_scan", 32'(bus.sdSCAN), 32'd0);
    bus.sdDONE = 1'b1;
    @(negedge clk);
    bus.sdDONE = 1'b0;
    chk("arst_next_ack", 32'(bus.drvACK), 32'h01);
    bus.drvREQ = 8'h00;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
